// File: rtl/branch_pkg.sv
// Shared constants and types for the branch resolution slice: funct3 condition
// codes, the resolver state type and the flush counter width.
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Wide enough for the largest legal FLUSH_CYCLES (15)
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Statistics counters stick at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/branch_cond_sel.sv
// Selects the comparator flag named by funct3; the two unassigned codes
// (010, 011) are reported as illegal and never select a flag.
module branch_cond_sel
    import branch_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_eq,
    input  logic       i_ne,
    input  logic       i_lt,
    input  logic       i_ltu,
    input  logic       i_ge,
    input  logic       i_geu,
    output logic       o_cond,
    output logic       o_illegal
);

    // funct3 to flag mux
    always_comb begin
        o_cond    = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            BEQ:     o_cond = i_eq;
            BNE:     o_cond = i_ne;
            BLT:     o_cond = i_lt;
            BGE:     o_cond = i_ge;
            BLTU:    o_cond = i_ltu;
            BGEU:    o_cond = i_geu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves one control-transfer instruction per handshake into a registered
// next PC / link result, with redirect pulse and flush window.
// Optional feature macro: BRANCH_STATS_EN adds branch_count / taken_count.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int dataW        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [dataW-1:0] pc,
    input  logic [dataW-1:0] imm,
    input  logic [dataW-1:0] rs1,
    input  logic [2:0]       funct3,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             EQ,
    input  logic             NE,
    input  logic             LT,
    input  logic             LTU,
    input  logic             GE,
    input  logic             GEU,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataW-1:0] next_pc,
    output logic [dataW-1:0] link,
    output logic             taken,
    output logic             misalign,
    output logic             illegal,
    output logic             redirect,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      branch_count,
    output logic [31:0]      taken_count
`endif
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [dataW-1:0] r_next_pc;
    logic [dataW-1:0] r_link;
    logic             r_taken;
    logic             r_misalign;
    logic             r_illegal;
    logic             r_redirect;

    logic             w_cond;
    logic             w_code_illegal;
    logic             w_is_xfer;
    logic [dataW-1:0] w_link;
    logic [dataW-1:0] w_pc_tgt;
    logic [dataW-1:0] w_jalr_sum;
    logic [dataW-1:0] w_target;
    logic             w_illegal;
    logic             w_want_taken;
    logic             w_misalign;
    logic             w_taken;
    logic [dataW-1:0] w_next_pc;
    logic             w_in_ready;
    logic             w_accept;

    branch_cond_sel u_cond_sel (
        .i_funct3  (funct3),
        .i_eq      (EQ),
        .i_ne      (NE),
        .i_lt      (LT),
        .i_ltu     (LTU),
        .i_ge      (GE),
        .i_geu     (GEU),
        .o_cond    (w_cond),
        .o_illegal (w_code_illegal)
    );

    assign w_is_xfer    = is_branch | is_jal | is_jalr;
    assign w_link       = pc + {{(dataW-3){1'b0}}, 3'b100};
    assign w_pc_tgt     = pc + imm;
    assign w_jalr_sum   = rs1 + imm;
    assign w_target     = is_jalr ? (w_jalr_sum & {{(dataW-1){1'b1}}, 1'b0}) : w_pc_tgt;
    assign w_illegal    = is_branch & w_code_illegal;
    assign w_want_taken = is_jal | is_jalr | (is_branch & w_cond);
    // A misaligned target is reported but suppresses the transfer entirely
    assign w_misalign   = w_want_taken & w_target[1];
    assign w_taken      = w_want_taken & ~w_target[1];
    assign w_next_pc    = w_taken ? w_target : w_link;

    assign w_in_ready = reset & (r_state == RUN) & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign next_pc   = r_next_pc;
    assign link      = r_link;
    assign taken     = r_taken;
    assign misalign  = r_misalign;
    assign illegal   = r_illegal;
    assign redirect  = r_redirect;
    assign flush     = (r_state == FLUSH);

    // Flush window sequencer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept && w_taken) begin
                        r_state <= FLUSH;
                        r_cnt   <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        r_state <= RUN;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Result register; redirect pulses regardless of downstream backpressure
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_next_pc   <= {dataW{1'b0}};
            r_link      <= {dataW{1'b0}};
            r_taken     <= 1'b0;
            r_misalign  <= 1'b0;
            r_illegal   <= 1'b0;
            r_redirect  <= 1'b0;
        end else begin
            r_redirect <= w_accept & w_taken;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_next_pc   <= w_next_pc;
                r_link      <= w_link;
                r_taken     <= w_taken;
                r_misalign  <= w_misalign;
                r_illegal   <= w_illegal;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_taken_count;

    assign branch_count = r_branch_count;
    assign taken_count  = r_taken_count;

    // Saturating transfer and redirect counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_branch_count <= 32'd0;
            r_taken_count  <= 32'd0;
        end else begin
            if (w_accept && w_is_xfer) begin
                r_branch_count <= sat_inc(r_branch_count);
            end
            if (w_accept && w_taken) begin
                r_taken_count <= sat_inc(r_taken_count);
            end
        end
    end
`else
    logic w_unused_xfer;
    assign w_unused_xfer = w_is_xfer;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table plus hand-written
// backpressure, back-to-back and reset-during-flush sequences.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc, imm, rs1;
    logic [2:0]  funct3;
    logic        is_branch, is_jal, is_jalr;
    logic        EQ, NE, LT, LTU, GE, GEU;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] next_pc, link;
    logic        taken, misalign, illegal, redirect, flush;

    branch_resolve #(.dataW(32), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .rs1(rs1), .funct3(funct3),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
        .out_valid(out_valid), .out_ready(out_ready),
        .next_pc(next_pc), .link(link), .taken(taken),
        .misalign(misalign), .illegal(illegal),
        .redirect(redirect), .flush(flush)
    );

    always #5 clock = ~clock;

    // fl = {EQ, NE, LT, LTU, GE, GEU}; cls = {is_branch, is_jal, is_jalr}
    typedef struct {
        logic [31:0] pc, imm, rs1;
        logic [2:0]  f3;
        logic [2:0]  cls;
        logic [5:0]  fl;
        logic [31:0] e_npc, e_link;
        logic        e_tk, e_mis, e_ill;
    } vec_t;

    vec_t vecs[12];
    vec_t cur_exp;
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [31:0] p, input logic [31:0] im, input logic [31:0] r,
                                input logic [2:0] f, input logic [2:0] c, input logic [5:0] fl,
                                input logic [31:0] npc, input logic [31:0] lk,
                                input logic tk, input logic mis, input logic ill);
        vec_t v;
        v.pc = p; v.imm = im; v.rs1 = r; v.f3 = f; v.cls = c; v.fl = fl;
        v.e_npc = npc; v.e_link = lk; v.e_tk = tk; v.e_mis = mis; v.e_ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc = v.pc; imm = v.imm; rs1 = v.rs1; funct3 = v.f3;
        {is_branch, is_jal, is_jalr} = v.cls;
        {EQ, NE, LT, LTU, GE, GEU} = v.fl;
        cur_exp  = v;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        {is_branch, is_jal, is_jalr} = 3'b000;
    endtask

    task automatic check_result(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".next_pc"}, next_pc, e.e_npc);
            chk({tag, ".link"}, link, e.e_link);
            chk({tag, ".taken"}, {31'd0, taken}, {31'd0, e.e_tk});
            chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.e_mis});
            chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.e_ill});
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".next_pc"}, next_pc, 32'd0);
        chk({tag, ".link"}, link, 32'd0);
        chk({tag, ".taken"}, {31'd0, taken}, 32'd0);
        chk({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
        chk({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Scoreboard push on every observed handshake
    always @(posedge clock) begin
        if (reset && in_valid && in_ready) sb_q.push_back(cur_exp);
    end

    initial begin
        //            pc            imm           rs1           f3      cls     flags      npc           link          tk mis ill
        vecs[0]  = mk(32'h100,      32'h20,       32'h0,        3'b000, 3'b100, 6'b100000, 32'h120,      32'h104,      1, 0, 0);
        vecs[1]  = mk(32'h200,      32'hFFFFFFF8, 32'h0,        3'b110, 3'b100, 6'b101011, 32'h204,      32'h204,      0, 0, 0);
        vecs[2]  = mk(32'h300,      32'h4,        32'h1001,     3'b000, 3'b001, 6'b000000, 32'h1004,     32'h304,      1, 0, 0);
        vecs[3]  = mk(32'h300,      32'h4,        32'h1002,     3'b000, 3'b001, 6'b000000, 32'h304,      32'h304,      0, 1, 0);
        vecs[4]  = mk(32'h400,      32'h40,       32'h0,        3'b010, 3'b100, 6'b111111, 32'h404,      32'h404,      0, 0, 1);
        vecs[5]  = mk(32'hFFFFFFFC, 32'h10,       32'h0,        3'b000, 3'b010, 6'b000000, 32'hC,        32'h0,        1, 0, 0);
        vecs[6]  = mk(32'h500,      32'h40,       32'h0,        3'b001, 3'b100, 6'b010000, 32'h540,      32'h504,      1, 0, 0);
        vecs[7]  = mk(32'h600,      32'h10,       32'h0,        3'b101, 3'b100, 6'b001100, 32'h604,      32'h604,      0, 0, 0);
        vecs[8]  = mk(32'h700,      32'h80,       32'h0,        3'b000, 3'b000, 6'b111111, 32'h704,      32'h704,      0, 0, 0);
        vecs[9]  = mk(32'h800,      32'hFFFFFF00, 32'h0,        3'b100, 3'b100, 6'b001000, 32'h700,      32'h804,      1, 0, 0);
        vecs[10] = mk(32'h900,      32'h8,        32'h0,        3'b111, 3'b100, 6'b000001, 32'h908,      32'h904,      1, 0, 0);
        vecs[11] = mk(32'hA00,      32'h8,        32'h0,        3'b001, 3'b100, 6'b101011, 32'hA04,      32'hA04,      0, 0, 0);

        reset = 1'b0; out_ready = 1'b1;
        pc = 32'd0; imm = 32'd0; rs1 = 32'd0; funct3 = 3'd0;
        {EQ, NE, LT, LTU, GE, GEU} = 6'd0;
        cur_exp = vecs[0];
        idle();
        #12;
        check_reset_state("reset");
        @(negedge clock); reset = 1'b1;
        #1 chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clock); drive(vecs[i]);
            #1 chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clock); #1 idle();
            @(negedge clock);
            check_result($sformatf("v%0d", i));
            chk($sformatf("v%0d.redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_tk});
            chk($sformatf("v%0d.flush", i), {31'd0, flush}, {31'd0, vecs[i].e_tk});
            chk($sformatf("v%0d.busy", i), {31'd0, in_ready}, {31'd0, ~vecs[i].e_tk});
            if (vecs[i].e_tk) begin
                @(negedge clock);
                chk($sformatf("v%0d.redirect2", i), {31'd0, redirect}, 32'd0);
                chk($sformatf("v%0d.flush2", i), {31'd0, flush}, 32'd1);
                chk($sformatf("v%0d.busy2", i), {31'd0, in_ready}, 32'd0);
                @(negedge clock);
                chk($sformatf("v%0d.flush3", i), {31'd0, flush}, 32'd0);
                chk($sformatf("v%0d.ready3", i), {31'd0, in_ready}, 32'd1);
            end
        end

        // Back-to-back not-taken accepts
        @(negedge clock); drive(vecs[1]);
        @(posedge clock); #1 drive(vecs[7]);
        @(negedge clock);
        check_result("b2b0");
        chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1 idle();
        @(negedge clock);
        check_result("b2b1");

        // Backpressure hold, then accept+drain replacement
        @(negedge clock); out_ready = 1'b0; drive(vecs[11]);
        @(posedge clock); #1 drive(vecs[8]);
        @(negedge clock);
        check_result("stall0");
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clock);
            chk($sformatf("stall%0d.valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.next_pc", c), next_pc, 32'hA04);
            chk($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("replace.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1 idle();
        @(negedge clock);
        check_result("replace");

        // Reset during the second flush cycle
        @(negedge clock); drive(vecs[0]);
        @(posedge clock); #1 idle();
        @(negedge clock);
        check_result("rflush");
        chk("rflush.flush1", {31'd0, flush}, 32'd1);
        @(posedge clock); #1 reset = 1'b0;
        #1 check_reset_state("mid_flush_reset");
        sb_q.delete();
        @(negedge clock); reset = 1'b1; drive(vecs[6]);
        #1 chk("post_reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1 idle();
        @(negedge clock);
        check_result("post_reset");
        chk("post_reset.redirect", {31'd0, redirect}, 32'd1);
        repeat (3) @(negedge clock);
        chk("final.flush", {31'd0, flush}, 32'd0);
        chk("final.sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
